uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per character.
REQ-002 SHALL have parameter CLK_DIV, default 16, clock cycles per bit period (legal range 2..65535).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port tx_en  input  1  transmit enable, level; 1 permits new frames.
REQ-006 SHALL have port fifo_empty  input  1  TX FIFO empty flag.
REQ-007 SHALL have port fifo_rd_data  input  DATA_WIDTH  TX FIFO read data, registered, valid the cycle after an accepted pop.
REQ-008 SHALL have port fifo_rd_en  output  1  single-cycle pop strobe to TX FIFO.
REQ-009 SHALL have port txd  output  1  serial line, idle high.
REQ-010 SHALL have port busy  output  1  high from pop strobe through last stop-bit cycle.
REQ-011 SHALL have port frame_done  output  1  single-cycle pulse in the cycle after the stop bit ends.

Function
REQ-012 SHALL implement FSM states IDLE, FETCH, START, DATA, STOP.
REQ-013 IDLE: when tx_en=1 and fifo_empty=0, SHALL assert fifo_rd_en for exactly one cycle and go to FETCH; otherwise stay in IDLE, txd=1.
REQ-014 FETCH: SHALL capture fifo_rd_data into a DATA_WIDTH shift register at cycle end, go to START; fifo_rd_en=0.
REQ-015 START: txd=0 for exactly CLK_DIV cycles, then go to DATA.
REQ-016 DATA: SHALL send DATA_WIDTH bits LSB first, each held exactly CLK_DIV cycles; bit counter width $clog2(DATA_WIDTH)+1; after last bit go to STOP.
REQ-017 STOP: txd=1 for exactly CLK_DIV cycles, then go to IDLE with frame_done=1 in the first IDLE cycle.
REQ-018 Frame length SHALL be (DATA_WIDTH+2)*CLK_DIV cycles of txd; first txd=0 cycle SHALL be 2 cycles after the fifo_rd_en cycle.
REQ-019 Back-to-back: with FIFO non-empty, the IDLE cycle after STOP SHALL issue the next pop; inter-frame gap is exactly 2 extra txd=1 cycles.
REQ-020 Baud counter SHALL count 0..CLK_DIV-1, clear on every state entry, and wrap to 0 on bit boundary; no drift across bits.
REQ-021 tx_en deasserted mid-frame SHALL not abort; current frame completes, no further pop until tx_en=1.
REQ-022 fifo_empty rising during FETCH..STOP SHALL have no effect on the current frame.
REQ-023 fifo_rd_en SHALL never be asserted while fifo_empty=1 or outside IDLE.
REQ-024 txd SHALL be driven from a register (glitch-free).

Reset
REQ-025 rstn=0 at a rising edge SHALL force state IDLE, txd=1, fifo_rd_en=0, busy=0, frame_done=0, counters and shift register 0.
REQ-026 Reset mid-frame SHALL abort the frame; txd=1 from the first edge with rstn=0; the popped byte is lost.
REQ-027 After rstn returns high, first pop SHALL occur no earlier than the next cycle.

Structure
REQ-028 Package uart_pkg SHALL hold FSM state encoding constants and defaults for DATA_WIDTH and CLK_DIV, shared with the RX side.
REQ-029 Baud counter SHALL be a sub-module uart_baud_cnt (inputs clk, rstn, clr; output tick on count CLK_DIV-1).
REQ-030 Total RTL SHALL be one top plus uart_baud_cnt; no other hierarchy.

Verification (CLK_DIV=4, DATA_WIDTH=8)
REQ-031 Reset: rstn=0 for 3 cycles mid-frame -> txd=1, busy=0, fifo_rd_en=0 from first reset edge.
REQ-032 Single byte 0xA5, tx_en=1 -> one rd_en pulse; txd 4-cycle bits 0,1,0,1,0,0,1,0,1,1; 40 cycles; frame_done once.
REQ-033 Two bytes 0x00, 0xFF queued -> two frames, exactly 2 idle-high cycles between stop of first and start of second.
REQ-034 tx_en dropped at bit 3 of 0x3C with 2 more bytes queued -> frame completes, no further rd_en until tx_en=1.
REQ-035 fifo_empty=1, tx_en=1 for 100 cycles -> fifo_rd_en never asserted, txd=1, busy=0.
REQ-036 Scoreboard: 256 random bytes through TX FIFO -> decoded txd stream matches input order, rd_en count = 256.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM state encoding and parameter defaults (TX and RX sides)
package uart_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CLK_DIV    = 16;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_t;
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, counts 0..CLK_DIV-1 and wraps
// Ports: clk - system clock; rstn - sync active-low reset;
//        clr - restart count at 0 next cycle; tick - high while count == CLK_DIV-1
module uart_baud_cnt import uart_pkg::*; #(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV);
    logic [CW-1:0] r_cnt;
    assign tick = (r_cnt == CW'(CLK_DIV - 1));
    always_ff @(posedge clk) begin
        if (!rstn || clr || tick) r_cnt <= '0;
        else                      r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit controller popping characters from a TX FIFO
// Ports: clk, rstn (sync active-low); tx_en - permit new frames;
//        fifo_empty, fifo_rd_data - FIFO status and registered read data;
//        fifo_rd_en - one-cycle pop; txd - serial line (registered, idle high);
//        busy - pop through last stop cycle; frame_done - pulse after stop bit
module uart_tx_ctrl import uart_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CLK_DIV    = DEF_CLK_DIV
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  txd,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int BW = $clog2(DATA_WIDTH) + 1;
    uart_state_t           r_state, w_state_next;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
    logic [BW-1:0]         r_bit, w_bit_next;
    logic                  r_txd, r_done, r_rdy;
    logic                  w_tick, w_pop, w_txd_next, w_clr;
    // restarting the baud count on every state change keeps each bit exactly CLK_DIV long
    assign w_clr = (w_state_next != r_state);
    uart_baud_cnt #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk  (clk),
        .rstn (rstn),
        .clr  (w_clr),
        .tick (w_tick)
    );
    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_bit_next   = r_bit;
        w_pop        = 1'b0;
        case (r_state)
            // r_rdy holds off the first pop until one full cycle out of reset
            ST_IDLE:  if (r_rdy && tx_en && !fifo_empty) begin
                          w_pop        = 1'b1;
                          w_state_next = ST_FETCH;
                      end
            ST_FETCH: begin
                          w_shift_next = fifo_rd_data;
                          w_bit_next   = '0;
                          w_state_next = ST_START;
                      end
            ST_START: if (w_tick) w_state_next = ST_DATA;
            ST_DATA:  if (w_tick) begin
                          w_shift_next = r_shift >> 1;
                          w_bit_next   = r_bit + 1'b1;
                          if (r_bit == BW'(DATA_WIDTH - 1)) w_state_next = ST_STOP;
                      end
            ST_STOP:  if (w_tick) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
        // txd is registered, so it is computed from where the FSM is going next
        w_txd_next = (w_state_next == ST_START) ? 1'b0 :
                     (w_state_next == ST_DATA)  ? w_shift_next[0] : 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_txd   <= 1'b1;
            r_done  <= 1'b0;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_bit   <= w_bit_next;
            r_txd   <= w_txd_next;
            r_done  <= (r_state == ST_STOP) && w_tick;
            r_rdy   <= 1'b1;
        end
    end
    assign fifo_rd_en = w_pop;
    assign txd        = r_txd;
    assign busy       = (r_state != ST_IDLE) || w_pop;
    assign frame_done = r_done;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed self-checking bench for uart_tx_ctrl (DATA_WIDTH=8, CLK_DIV=4)
module tb_uart_tx_ctrl;
    localparam int DW = 8;
    localparam int CD = 4;
    logic          clk = 1'b0;
    logic          rstn, tx_en, fifo_empty, fifo_rd_en, txd, busy, frame_done;
    logic [DW-1:0] fifo_rd_data;
    logic [7:0]    mem [0:1023];
    logic [7:0]    expq [$];
    int            wr_ptr = 0, rd_ptr = 0, rd_total = 0, rst_edges = 0;
    int            checks = 0, failures = 0;
    logic          tt [0:199], tr [0:199], tf [0:199], tbz [0:199];
    int            cnt_rd, cnt_fd, cnt_low, cnt_busy;
    logic [39:0]   v;
    int            base;

    uart_tx_ctrl #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .tx_en        (tx_en),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .txd          (txd),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // TX FIFO model with registered read data
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_rd_en === 1'b1) begin
            rd_total <= rd_total + 1;
            if (!fifo_empty) begin
                fifo_rd_data <= mem[rd_ptr % 1024];
                rd_ptr       <= rd_ptr + 1;
            end
        end
        if (rstn === 1'b0) rst_edges <= rst_edges + 1;
    end

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input bit expect_it);
        mem[wr_ptr % 1024] = b;
        wr_ptr++;
        if (expect_it) expq.push_back(b);
    endtask

    task automatic capture(input int n, input int drop_at);
        cnt_rd = 0; cnt_fd = 0; cnt_low = 0; cnt_busy = 0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            tt[k] = txd; tr[k] = fifo_rd_en; tf[k] = frame_done; tbz[k] = busy;
            cnt_rd += int'(fifo_rd_en); cnt_fd += int'(frame_done);
            cnt_low += int'(!txd); cnt_busy += int'(busy);
            if (k == drop_at) tx_en = 1'b0;
        end
    endtask

    // pop strobe must never hit an empty FIFO
    always @(negedge clk) if (fifo_rd_en === 1'b1) chk("rd_en_while_empty", fifo_empty, 0);

    // line decoder: samples mid-bit, abandons a frame cut by reset, scores against expq
    initial begin
        logic [7:0] d;
        int         r0, j;
        bit         ok;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && txd === 1'b0) begin
                r0 = rst_edges; ok = 1'b1; d = '0;
                for (int c = 1; c <= 38; c++) begin
                    @(negedge clk);
                    if (rst_edges != r0) begin ok = 1'b0; break; end
                    if (c % 4 == 2) begin
                        j = (c - 2) / 4;
                        if (j == 0)      chk("start_bit", txd, 0);
                        else if (j <= 8) d[j-1] = txd;
                        else             chk("stop_bit", txd, 1);
                    end
                end
                if (ok) begin
                    chk("frame_expected", expq.size() != 0, 1);
                    if (expq.size() != 0) chk("rx_byte", d, expq.pop_front());
                end
            end
        end
    end

    initial begin
        rstn = 1'b0; tx_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_txd", txd, 1);
        chk("reset_busy", busy, 0);
        chk("reset_rd_en", fifo_rd_en, 0);
        chk("reset_frame_done", frame_done, 0);
        @(negedge clk); rstn = 1'b1; tx_en = 1'b1;
        repeat (3) @(negedge clk);

        // single byte 0xA5
        push(8'hA5, 1);
        capture(44, -1);
        chk("a5_pop", tr[0], 1);
        chk("a5_busy_at_pop", tbz[0], 1);
        chk("a5_pop_count", cnt_rd, 1);
        chk("a5_fetch_idle_high", tt[1], 1);
        for (int k = 0; k < 40; k++) v[39-k] = tt[2+k];
        chk("a5_waveform", v, 40'h0F0F00F0FF);
        chk("a5_done_count", cnt_fd, 1);
        chk("a5_done_cycle", tf[42], 1);
        chk("a5_busy_last_stop", tbz[41], 1);
        chk("a5_busy_after", tbz[42], 0);

        // reset in the middle of a frame; popped byte is lost
        @(negedge clk); push(8'h55, 0);
        repeat (14) @(negedge clk);
        rstn = 1'b0; push(8'h11, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("midrst_txd", txd, 1);
            chk("midrst_busy", busy, 0);
            chk("midrst_rd_en", fifo_rd_en, 0);
            chk("midrst_done", frame_done, 0);
        end
        @(negedge clk); rstn = 1'b1; #1;
        chk("release_no_pop", fifo_rd_en, 0);
        @(negedge clk); #1;
        chk("release_pop_next", fifo_rd_en, 1);
        repeat (45) @(negedge clk);
        chk("midrst_drained", expq.size(), 0);

        // back-to-back 0x00, 0xFF
        @(negedge clk); push(8'h00, 1); push(8'hFF, 1);
        capture(90, -1);
        chk("b2b_pop0", tr[0], 1);
        chk("b2b_pop1", tr[42], 1);
        chk("b2b_pop_count", cnt_rd, 2);
        chk("b2b_stop_end", tt[41], 1);
        chk("b2b_gap", {tt[42], tt[43], tt[44]}, 3'b110);
        chk("b2b_done_count", cnt_fd, 2);
        chk("b2b_done_second", tf[84], 1);
        chk("b2b_drained", expq.size(), 0);

        // tx_en dropped at bit 3 of 0x3C with two more bytes queued
        @(negedge clk); push(8'h3C, 1); push(8'hAA, 1); push(8'h55, 1);
        capture(60, 19);
        chk("dis_pop_count", cnt_rd, 1);
        for (int k = 0; k < 40; k++) v[39-k] = tt[2+k];
        chk("dis_waveform", v, 40'h000FFFF00F);
        chk("dis_done", tf[42], 1);
        chk("dis_no_pop_after", tr[42], 0);
        chk("dis_idle_busy", tbz[42], 0);
        capture(30, -1);
        chk("dis_hold_no_pop", cnt_rd, 0);
        @(negedge clk); tx_en = 1'b1; #1;
        chk("reenable_pop", fifo_rd_en, 1);
        repeat (90) @(negedge clk);
        chk("dis_drained", expq.size(), 0);

        // empty FIFO with tx_en high
        capture(100, -1);
        chk("empty_pop_count", cnt_rd, 0);
        chk("empty_txd_low", cnt_low, 0);
        chk("empty_busy", cnt_busy, 0);

        // 256 random bytes through the FIFO
        base = rd_total;
        for (int i = 0; i < 256; i++) push(8'($urandom_range(0, 255)), 1);
        for (int i = 0; i < 256 * 42 + 200 && expq.size() != 0; i++) @(negedge clk);
        chk("rand_drained", expq.size(), 0);
        repeat (10) @(negedge clk);
        chk("rand_pop_count", rd_total - base, 256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
